multi_cycle_ctrl_fsm: RTL and testbench

MULTI_CYCLE_CTRL_FSM -- requirements
Module: multi_cycle_ctrl_fsm

---
 rtl/cpu_ctrl_pkg.sv | 82 ++++++++
 rtl/multi_cycle_ctrl_fsm_if.sv | 37 +++
 rtl/insn_class_decode.sv | 52 +++++
 rtl/multi_cycle_ctrl_fsm.sv | 152 +++++++++++++++
 tb/tb_multi_cycle_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared codes for the multi-cycle CPU control FSM
// Purpose: state codes, instruction classes, opcode/funct constants,
//          ALUOp, PCSrc and RegDst codes, plus small class helpers.
// Ports: none (package).
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  typedef enum logic [4:0] {
    C_NOP, C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SLL, C_JR,
    C_ADDI, C_ORI, C_SLTI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_HALT
  } insn_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  function automatic logic [2:0] alu_op_of(insn_class_t c);
    case (c)
      C_SUB, C_BEQ, C_BNE: return ALU_SUB;
      C_AND:               return ALU_AND;
      C_OR, C_ORI:         return ALU_OR;
      C_SLT, C_SLTI:       return ALU_SLT;
      C_SLL:               return ALU_SLL;
      default:             return ALU_ADD;
    endcase
  endfunction

  // Classes that write the register file in WB.
  function automatic logic writes_reg_wb(insn_class_t c);
    case (c)
      C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SLL,
      C_ADDI, C_ORI, C_SLTI, C_LW: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

  function automatic logic is_rtype_alu(insn_class_t c);
    case (c)
      C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SLL: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_fsm_if.sv
// rtl/multi_cycle_ctrl_fsm_if.sv - control bundle between FSM and datapath
// Purpose: groups the instruction fields, ALU flags and control strobes.
// Ports: master = control FSM (reads insn/flags, drives strobes),
//        slave  = datapath (drives insn/flags, reads strobes).
interface multi_cycle_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       sign;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRw;
  logic       RegWre;
  logic [1:0] RegDst;
  logic       WrRegDSrc;
  logic       ExtSel;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic [2:0] ALUOp;
  logic       DBDataSrc;
  logic       mRD;
  logic       mWR;
  logic [1:0] PCSrc;
  logic [2:0] state;

  modport master (
    input  opcode, funct, zero, sign,
    output PCWre, IRWre, InsMemRw, RegWre, RegDst, WrRegDSrc, ExtSel,
           ALUSrcA, ALUSrcB, ALUOp, DBDataSrc, mRD, mWR, PCSrc, state
  );

  modport slave (
    output opcode, funct, zero, sign,
    input  PCWre, IRWre, InsMemRw, RegWre, RegDst, WrRegDSrc, ExtSel,
           ALUSrcA, ALUSrcB, ALUOp, DBDataSrc, mRD, mWR, PCSrc, state
  );
endinterface

// File: rtl/insn_class_decode.sv
// rtl/insn_class_decode.sv - combinational opcode/funct to instruction class
// Purpose: maps the raw instruction fields to insn_class_t; anything not
//          recognised becomes C_NOP.
// Ports: i_opcode, i_funct (instruction fields) -> o_class.
module insn_class_decode
  import cpu_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP  = 6'b111111,
  parameter logic [5:0] JR_FUNCT = 6'b001000
) (
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  output insn_class_t o_class
);

  always_comb begin
    o_class = C_NOP;
    // HALT_OP is a parameter, so it is tested ahead of the fixed opcodes.
    if (i_opcode == HALT_OP) begin
      o_class = C_HALT;
    end else begin
      case (i_opcode)
        OP_RTYPE: begin
          if (i_funct == JR_FUNCT) begin
            o_class = C_JR;
          end else begin
            case (i_funct)
              FN_ADD:  o_class = C_ADD;
              FN_SUB:  o_class = C_SUB;
              FN_AND:  o_class = C_AND;
              FN_OR:   o_class = C_OR;
              FN_SLT:  o_class = C_SLT;
              FN_SLL:  o_class = C_SLL;
              default: o_class = C_NOP;
            endcase
          end
        end
        OP_ADDI: o_class = C_ADDI;
        OP_ORI:  o_class = C_ORI;
        OP_SLTI: o_class = C_SLTI;
        OP_LW:   o_class = C_LW;
        OP_SW:   o_class = C_SW;
        OP_BEQ:  o_class = C_BEQ;
        OP_BNE:  o_class = C_BNE;
        OP_J:    o_class = C_J;
        OP_JAL:  o_class = C_JAL;
        default: o_class = C_NOP;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl_fsm.sv
// rtl/multi_cycle_ctrl_fsm.sv - multi-cycle CPU control state machine
// Purpose: sequences IF/ID/EXE/MEM/WB/HALT and drives datapath strobes.
// Ports: CLK, Reset (async, active high); opcode, funct, zero, sign in;
//        PCWre, IRWre, InsMemRw, RegWre, RegDst, WrRegDSrc, ExtSel,
//        ALUSrcA, ALUSrcB, ALUOp, DBDataSrc, mRD, mWR, PCSrc, state out.
module multi_cycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP  = 6'b111111,
  parameter logic [5:0] JR_FUNCT = 6'b001000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRw,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       ExtSel,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc,
  output logic [2:0] state
);

  state_t      r_state;
  insn_class_t r_class;
  state_t      w_next;
  insn_class_t w_class;
  logic        w_final;
  logic        w_unused_sign;

  // sign only matters to the ALU's slt path, never to sequencing.
  assign w_unused_sign = sign;

  insn_class_decode #(
    .HALT_OP  (HALT_OP),
    .JR_FUNCT (JR_FUNCT)
  ) u_decode (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_class  (w_class)
  );

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:  w_next = S_ID;
      S_ID: begin
        case (r_class)
          C_HALT:                    w_next = S_HALT;
          C_J, C_JAL, C_JR, C_NOP:   w_next = S_IF;
          default:                   w_next = S_EXE;
        endcase
      end
      S_EXE: begin
        case (r_class)
          C_LW, C_SW:   w_next = S_MEM;
          C_BEQ, C_BNE: w_next = S_IF;
          default:      w_next = S_WB;
        endcase
      end
      S_MEM:  w_next = (r_class == C_LW) ? S_WB : S_IF;
      S_WB:   w_next = S_IF;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  // The class is captured only on the IF->ID edge so IR changes later in
  // the instruction cannot disturb sequencing.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IF;
      r_class <= C_NOP;
    end else begin
      r_state <= w_next;
      if (r_state == S_IF) begin
        r_class <= w_class;
      end
    end
  end

  // The instruction's last state is the one that returns to IF; HALT never does.
  assign w_final = (w_next == S_IF);
  assign state   = r_state;

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRw  = 1'b0;
    RegWre    = 1'b0;
    RegDst    = RD_RT;
    WrRegDSrc = 1'b1;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = PC_NEXT;
    ExtSel    = (r_class != C_ORI);
    ALUSrcA   = (r_class == C_SLL);
    ALUSrcB   = (r_class == C_ADDI) || (r_class == C_ORI) || (r_class == C_SLTI) ||
                (r_class == C_LW)   || (r_class == C_SW);
    ALUOp     = ((r_state == S_EXE) || (r_state == S_MEM) || (r_state == S_WB)) ?
                alu_op_of(r_class) : ALU_ADD;
    // Reset gates every strobe directly so an in-flight write dies at once.
    if (!Reset) begin
      IRWre    = (r_state == S_IF);
      InsMemRw = (r_state == S_IF);
      PCWre    = w_final;
      case (r_state)
        S_ID: begin
          case (r_class)
            C_J:  PCSrc = PC_JUMP;
            C_JR: PCSrc = PC_RS;
            C_JAL: begin
              PCSrc     = PC_JUMP;
              RegWre    = 1'b1;
              RegDst    = RD_RA;
              WrRegDSrc = 1'b0;
            end
            default: PCSrc = PC_NEXT;
          endcase
        end
        S_EXE: begin
          if (((r_class == C_BEQ) && zero) || ((r_class == C_BNE) && !zero)) begin
            PCSrc = PC_BRANCH;
          end
        end
        S_MEM: begin
          mRD = (r_class == C_LW);
          mWR = (r_class == C_SW);
        end
        S_WB: begin
          RegWre    = writes_reg_wb(r_class);
          RegDst    = is_rtype_alu(r_class) ? RD_RD : RD_RT;
          DBDataSrc = (r_class == C_LW);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// tb/tb_multi_cycle_ctrl_fsm.sv - self-checking bench for multi_cycle_ctrl_fsm
module tb_multi_cycle_ctrl_fsm;

  logic CLK = 1'b0;
  logic Reset;

  multi_cycle_ctrl_fsm_if bus ();

  multi_cycle_ctrl_fsm #(
    .HALT_OP  (6'b111111),
    .JR_FUNCT (6'b001000)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .opcode    (bus.opcode),
    .funct     (bus.funct),
    .zero      (bus.zero),
    .sign      (bus.sign),
    .PCWre     (bus.PCWre),
    .IRWre     (bus.IRWre),
    .InsMemRw  (bus.InsMemRw),
    .RegWre    (bus.RegWre),
    .RegDst    (bus.RegDst),
    .WrRegDSrc (bus.WrRegDSrc),
    .ExtSel    (bus.ExtSel),
    .ALUSrcA   (bus.ALUSrcA),
    .ALUSrcB   (bus.ALUSrcB),
    .ALUOp     (bus.ALUOp),
    .DBDataSrc (bus.DBDataSrc),
    .mRD       (bus.mRD),
    .mWR       (bus.mWR),
    .PCSrc     (bus.PCSrc),
    .state     (bus.state)
  );

  always #5 CLK = ~CLK;

  // st holds the state sequence, state k at bits [3k+2:3k].
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    int          n;
    logic [14:0] st;
    logic [2:0]  aluop;
    logic        srca;
    logic        srcb;
    logic        ext;
    logic        rw;
    logic [2:0]  wst;
    logic [1:0]  rdst;
    logic        wsrc;
    logic [1:0]  pcs;
    logic        rd;
    logic        wr;
  } vec_t;

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] ctrl;
    logic        chk_alu;
    logic [5:0]  alu;
  } exp_t;

  localparam logic [14:0] SQ2  = {3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
  localparam logic [14:0] SQ3  = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] SQ4W = {3'd0, 3'd4, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] SQ4M = {3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] SQ5  = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  vec_t vecs [20];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [11:0] ctrl_now();
    return {bus.PCWre, bus.IRWre, bus.InsMemRw, bus.RegWre, bus.RegDst, bus.WrRegDSrc,
            bus.mRD, bus.mWR, bus.DBDataSrc, bus.PCSrc};
  endfunction

  function automatic logic [5:0] alu_now();
    return {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push_vec(input vec_t v);
    for (int k = 0; k < v.n; k++) begin
      logic [2:0] s;
      logic       fin;
      logic       w;
      exp_t       e;
      s   = v.st[3*k +: 3];
      fin = (k == v.n - 1);
      w   = v.rw && (s == v.wst);
      e.st      = s;
      e.ctrl    = {fin, s == 3'd0, s == 3'd0, w, w ? v.rdst : 2'b00, w ? v.wsrc : 1'b1,
                   v.rd && (s == 3'd3), v.wr && (s == 3'd3), v.rd && (s == 3'd4),
                   fin ? v.pcs : 2'b00};
      e.chk_alu = (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
      e.alu     = {v.aluop, v.srca, v.srcb, v.ext};
      sb.push_back(e);
    end
  endtask

  // Entered right at a falling edge with the DUT in IF.
  task automatic run_vec(input int idx, input vec_t v);
    push_vec(v);
    for (int k = 0; k < v.n; k++) begin
      exp_t e;
      if (k == 0) begin
        bus.opcode = v.op;
        bus.funct  = v.fn;
        bus.zero   = v.z;
        bus.sign   = 1'($urandom);
      end
      if (k == 1) begin
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
      end
      #1;
      if (sb.size() == 0) begin
        chk($sformatf("v%0d c%0d scoreboard empty", idx, k), 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d c%0d state", idx, k), 32'(bus.state), 32'(e.st));
        chk($sformatf("v%0d c%0d ctrl", idx, k), 32'(ctrl_now()), 32'(e.ctrl));
        if (e.chk_alu) chk($sformatf("v%0d c%0d alu", idx, k), 32'(alu_now()), 32'(e.alu));
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

  initial begin
    //                op         fn         z     n  st    aluop   A     B     ext   rw    wst   rdst   wsrc  pcs    rd    wr
    vecs[0]  = '{6'b000000, 6'b100000, 1'b0, 4, SQ4W, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{6'b000000, 6'b100010, 1'b0, 4, SQ4W, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{6'b000000, 6'b100100, 1'b1, 4, SQ4W, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{6'b000000, 6'b100101, 1'b0, 4, SQ4W, 3'b011, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[4]  = '{6'b000000, 6'b101010, 1'b0, 4, SQ4W, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[5]  = '{6'b000000, 6'b000000, 1'b0, 4, SQ4W, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[6]  = '{6'b001000, 6'b010101, 1'b0, 4, SQ4W, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{6'b001101, 6'b000000, 1'b0, 4, SQ4W, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{6'b001010, 6'b100000, 1'b1, 4, SQ4W, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[9]  = '{6'b100011, 6'b000000, 1'b0, 5, SQ5,  3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    vecs[10] = '{6'b101011, 6'b000000, 1'b0, 4, SQ4M, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1};
    vecs[11] = '{6'b000100, 6'b000000, 1'b1, 3, SQ3,  3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[12] = '{6'b000100, 6'b000000, 1'b0, 3, SQ3,  3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[13] = '{6'b000101, 6'b000000, 1'b0, 3, SQ3,  3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[14] = '{6'b000101, 6'b000000, 1'b1, 3, SQ3,  3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[15] = '{6'b000010, 6'b000000, 1'b0, 2, SQ2,  3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0};
    vecs[16] = '{6'b000011, 6'b000000, 1'b0, 2, SQ2,  3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 2'b10, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[17] = '{6'b000000, 6'b001000, 1'b0, 2, SQ2,  3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0};
    vecs[18] = '{6'b010000, 6'b000000, 1'b0, 2, SQ2,  3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[19] = '{6'b000000, 6'b111111, 1'b0, 2, SQ2,  3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0};

    Reset      = 1'b1;
    bus.opcode = 6'b000000;
    bus.funct  = 6'b100000;
    bus.zero   = 1'b0;
    bus.sign   = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset state", 32'(bus.state), 32'd0);
    chk("reset ctrl strobes", 32'({bus.PCWre, bus.IRWre, bus.InsMemRw, bus.RegWre,
                                   bus.mRD, bus.mWR, bus.DBDataSrc}), 32'd0);
    chk("reset PCSrc", 32'(bus.PCSrc), 32'd0);
    chk("reset ALUOp", 32'(bus.ALUOp), 32'd0);
    chk("reset RegDst", 32'(bus.RegDst), 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

    // HALT parks the FSM with no PC update until reset.
    bus.opcode = 6'b111111;
    bus.funct  = 6'b000000;
    #1 chk("halt IF state", 32'(bus.state), 32'd0);
    @(negedge CLK);
    #1 chk("halt ID state", 32'(bus.state), 32'd1);
    chk("halt ID PCWre", 32'(bus.PCWre), 32'd0);
    @(negedge CLK);
    for (int i = 0; i < 12; i++) begin
      #1 chk($sformatf("halt c%0d state", i), 32'(bus.state), 32'd7);
      chk($sformatf("halt c%0d PCWre", i), 32'(bus.PCWre), 32'd0);
      bus.opcode = 6'b000000;
      @(negedge CLK);
    end
    #1 Reset = 1'b1;
    #1 chk("halt reset state", 32'(bus.state), 32'd0);
    chk("halt reset IRWre", 32'(bus.IRWre), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    run_vec(100, vecs[0]);

    // Reset during the MEM cycle of sw must kill mWR at once.
    bus.opcode = 6'b101011;
    bus.funct  = 6'b000000;
    #1 chk("swrst IF", 32'(bus.state), 32'd0);
    @(negedge CLK);
    #1 chk("swrst ID", 32'(bus.state), 32'd1);
    @(negedge CLK);
    #1 chk("swrst EXE", 32'(bus.state), 32'd2);
    @(negedge CLK);
    #1 chk("swrst MEM state", 32'(bus.state), 32'd3);
    chk("swrst MEM mWR", 32'(bus.mWR), 32'd1);
    #2 Reset = 1'b1;
    #1 chk("swrst mWR dropped", 32'(bus.mWR), 32'd0);
    chk("swrst state IF", 32'(bus.state), 32'd0);
    chk("swrst PCWre", 32'(bus.PCWre), 32'd0);
    @(posedge CLK);
    #1 chk("swrst held strobes", 32'({bus.PCWre, bus.RegWre, bus.mWR}), 32'd0);
    chk("swrst held state", 32'(bus.state), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    run_vec(101, vecs[9]);
    run_vec(102, vecs[16]);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
